// File: rtl/pic_prio_resolver.sv
// Interrupt priority resolver: request/in-service registers, rotating priority,
// interrupt output to the CPU and the two-pulse INTA vector handshake.
module pic_prio_resolver #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               ltim,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               smm,
  input  logic               aeoi,
  input  logic               auto_rot,
  input  logic               eoi_strb,
  input  logic               eoi_specific,
  input  logic [ID_W-1:0]    eoi_id,
  input  logic               set_pri_strb,
  input  logic [ID_W-1:0]    set_pri_id,
  input  logic               inta,
  output logic               int_out,
  output logic               vec_valid,
  output logic [ID_W-1:0]    vec_id,
  output logic               spurious,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr,
  output logic [ID_W-1:0]    pri_base
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_ACK2 = 1'b1;
  localparam logic [ID_W:0] NUM_W = (ID_W+1)'(NUM_IRQ);

  logic               state;
  logic [NUM_IRQ-1:0] irq_prev;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input logic [ID_W-1:0] b);
    logic [ID_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NUM_W) s = s - NUM_W;
    return s[ID_W-1:0];
  endfunction

  // Returns {found, rank} of the highest-priority set bit, rank 0 being pri_base.
  function automatic logic [ID_W:0] find_top(input logic [NUM_IRQ-1:0] vec, input logic [ID_W-1:0] base);
    logic [ID_W:0] res;
    res = '0;
    for (int k = NUM_IRQ-1; k >= 0; k--) begin
      if (vec[wrap_add(base, ID_W'(k))]) res = {1'b1, ID_W'(k)};
    end
    return res;
  endfunction

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NUM_IRQ-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  function automatic logic id_ok(input logic [ID_W-1:0] id);
    return int'({1'b0, id}) < NUM_IRQ;
  endfunction

  logic [NUM_IRQ-1:0] pend, blk_vec;
  logic [ID_W:0]      cand_top, blk_top, isr_top;
  logic [ID_W-1:0]    cand_id, isr_top_id;
  logic               int_next, first_ack, real_ack, second_ack;

  assign pend       = irr & ~imr;
  assign blk_vec    = smm ? (isr & ~imr) : isr;
  assign cand_top   = find_top(pend, pri_base);
  assign blk_top    = find_top(blk_vec, pri_base);
  assign isr_top    = find_top(isr, pri_base);
  assign cand_id    = wrap_add(pri_base, cand_top[ID_W-1:0]);
  assign isr_top_id = wrap_add(pri_base, isr_top[ID_W-1:0]);
  assign int_next   = cand_top[ID_W] &&
                      (!blk_top[ID_W] || (cand_top[ID_W-1:0] < blk_top[ID_W-1:0]));
  assign first_ack  = inta && (state == ST_IDLE);
  assign real_ack   = first_ack && int_out && cand_top[ID_W];
  assign second_ack = inta && (state == ST_ACK2);

  logic [NUM_IRQ-1:0] isr_set, isr_clr, irr_ack;
  logic               rot_req;
  logic [ID_W-1:0]    rot_id, pri_base_next;

  // EOI rotation takes precedence over AEOI rotation; set_pri_strb beats both.
  always_comb begin
    isr_set       = real_ack ? onehot(cand_id) : '0;
    irr_ack       = isr_set;
    isr_clr       = '0;
    rot_req       = 1'b0;
    rot_id        = '0;
    pri_base_next = pri_base;
    if (second_ack && aeoi && !spurious) begin
      isr_clr = isr_clr | onehot(vec_id);
      rot_req = auto_rot;
      rot_id  = vec_id;
    end
    if (eoi_strb) begin
      if (eoi_specific) begin
        if (id_ok(eoi_id)) begin
          isr_clr = isr_clr | onehot(eoi_id);
          rot_req = auto_rot;
          rot_id  = eoi_id;
        end
      end else if (isr_top[ID_W]) begin
        isr_clr = isr_clr | onehot(isr_top_id);
        rot_req = auto_rot;
        rot_id  = isr_top_id;
      end
    end
    if (rot_req) pri_base_next = wrap_add(rot_id, ID_W'(1));
    if (set_pri_strb && id_ok(set_pri_id)) pri_base_next = wrap_add(set_pri_id, ID_W'(1));
  end

  // spurious stays up through the vec_valid pulse so it can qualify it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      irq_prev  <= '0;
      irr       <= '0;
      isr       <= '0;
      pri_base  <= '0;
      int_out   <= 1'b0;
      vec_valid <= 1'b0;
      vec_id    <= '0;
      spurious  <= 1'b0;
    end else begin
      irq_prev  <= irq_in;
      irr       <= ltim ? (irq_in & ~irr_ack) : ((irr & ~irr_ack) | (irq_in & ~irq_prev));
      isr       <= (isr & ~isr_clr) | isr_set;
      pri_base  <= pri_base_next;
      int_out   <= first_ack ? 1'b0 : int_next;
      vec_valid <= second_ack;
      if (vec_valid) spurious <= 1'b0;
      if (first_ack) begin
        vec_id   <= real_ack ? cand_id : ID_W'(NUM_IRQ-1);
        spurious <= !real_ack;
        state    <= ST_ACK2;
      end else if (second_ack) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_pic_prio_resolver.sv
// Bench for pic_prio_resolver: directed scenarios with literal expectations plus
// a randomized run compared every cycle against a behavioural model.
module tb_pic_prio_resolver;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq_in = '0, imr = '0;
  logic       ltim = 0, smm = 0, aeoi = 0, auto_rot = 0;
  logic       eoi_strb = 0, eoi_specific = 0, set_pri_strb = 0, inta = 0;
  logic [2:0] eoi_id = '0, set_pri_id = '0;
  logic       int_out, vec_valid, spurious;
  logic [2:0] vec_id, pri_base;
  logic [7:0] irr, isr;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 0;

  pic_prio_resolver #(.NUM_IRQ(N), .ID_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .ltim(ltim), .imr(imr), .smm(smm),
    .aeoi(aeoi), .auto_rot(auto_rot), .eoi_strb(eoi_strb), .eoi_specific(eoi_specific),
    .eoi_id(eoi_id), .set_pri_strb(set_pri_strb), .set_pri_id(set_pri_id), .inta(inta),
    .int_out(int_out), .vec_valid(vec_valid), .vec_id(vec_id), .spurious(spurious),
    .irr(irr), .isr(isr), .pri_base(pri_base)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: priorities expressed as rank distance from the base.
  logic [7:0] m_irr, m_isr, m_prev;
  int         m_base, m_vid;
  logic       m_int, m_vv, m_spur, m_busy;

  function automatic int rank_of(int i, int base);
    return (i - base + N) % N;
  endfunction

  function automatic int best_of(logic [7:0] v, int base);
    int b = -1;
    for (int i = 0; i < N; i++)
      if (v[i] && (b < 0 || rank_of(i, base) < rank_of(b, base))) b = i;
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_irr = '0; m_isr = '0; m_prev = '0; m_base = 0; m_vid = 0;
      m_int = 0; m_vv = 0; m_spur = 0; m_busy = 0;
    end else begin
      int c, blk, t, nb;
      logic [7:0] n_isr, ack_clr;
      logic first, second, real_ack, intn;
      c      = best_of(m_irr & ~imr, m_base);
      blk    = best_of(smm ? (m_isr & ~imr) : m_isr, m_base);
      intn   = (c >= 0) && (blk < 0 || rank_of(c, m_base) < rank_of(blk, m_base));
      first  = inta && !m_busy;
      second = inta && m_busy;
      real_ack = first && m_int && (c >= 0);
      n_isr = m_isr; ack_clr = '0; nb = m_base;
      if (second && aeoi && !m_spur) begin
        n_isr[m_vid] = 1'b0;
        if (auto_rot) nb = (m_vid + 1) % N;
      end
      if (eoi_strb) begin
        t = eoi_specific ? int'(eoi_id) : best_of(m_isr, m_base);
        if (t >= 0) begin
          n_isr[t] = 1'b0;
          if (auto_rot) nb = (t + 1) % N;
        end
      end
      if (set_pri_strb) nb = (int'(set_pri_id) + 1) % N;
      if (real_ack) begin
        n_isr[c] = 1'b1;
        ack_clr[c] = 1'b1;
      end
      m_irr  = ltim ? (irq_in & ~ack_clr) : ((m_irr & ~ack_clr) | (irq_in & ~m_prev));
      m_prev = irq_in;
      m_isr  = n_isr;
      m_base = nb;
      m_int  = first ? 1'b0 : intn;
      if (m_vv) m_spur = 1'b0;
      m_vv   = second;
      if (first) begin
        m_vid  = real_ack ? c : N - 1;
        m_spur = !real_ack;
        m_busy = 1'b1;
      end else if (second) begin
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("int_out", 32'(int_out), 32'(m_int));
      checkOutput("vec_valid", 32'(vec_valid), 32'(m_vv));
      checkOutput("vec_id", 32'(vec_id), 32'(m_vid));
      checkOutput("spurious", 32'(spurious), 32'(m_spur));
      checkOutput("irr", 32'(irr), 32'(m_irr));
      checkOutput("isr", 32'(isr), 32'(m_isr));
      checkOutput("pri_base", 32'(pri_base), 32'(m_base));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    irq_in = '0; imr = '0; ltim = 0; smm = 0; aeoi = 0; auto_rot = 0;
    eoi_strb = 0; eoi_specific = 0; eoi_id = '0; set_pri_strb = 0; set_pri_id = '0; inta = 0;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic inta_first();
    inta = 1; tick(); inta = 0;
  endtask

  task automatic inta_second();
    tick(); inta = 1; tick(); inta = 0;
  endtask

  task automatic applyStimulus();
    tick();
    rst_n = ($urandom_range(0, 599) != 0);
    for (int i = 0; i < N; i++)
      if ($urandom_range(0, 7) == 0) irq_in[i] = ~irq_in[i];
    if ($urandom_range(0, 31) == 0) imr = 8'($urandom) & 8'($urandom);
    if ($urandom_range(0, 255) == 0) begin
      ltim = 1'($urandom); smm = 1'($urandom); aeoi = 1'($urandom); auto_rot = 1'($urandom);
    end
    eoi_strb     = ($urandom_range(0, 9) == 0);
    eoi_specific = 1'($urandom);
    eoi_id       = 3'($urandom);
    set_pri_strb = ($urandom_range(0, 39) == 0);
    set_pri_id   = 3'($urandom);
    inta         = !inta && ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    do_reset();
    chk_en = 1;
    checkOutput("rst_irr", 32'(irr), 32'h0);
    checkOutput("rst_int_out", 32'(int_out), 32'h0);
    checkOutput("rst_pri_base", 32'(pri_base), 32'h0);

    irq_in = 8'h08; tick();
    checkOutput("ir3_irr", 32'(irr), 32'h08);
    checkOutput("ir3_int_early", 32'(int_out), 32'h0);
    tick();
    checkOutput("ir3_int", 32'(int_out), 32'h1);
    inta_first();
    checkOutput("ir3_isr", 32'(isr), 32'h08);
    checkOutput("ir3_irr_clr", 32'(irr), 32'h00);
    checkOutput("ir3_int_drop", 32'(int_out), 32'h0);
    inta_second();
    checkOutput("ir3_vec_valid", 32'(vec_valid), 32'h1);
    checkOutput("ir3_vec_id", 32'(vec_id), 32'h3);
    tick();
    checkOutput("ir3_vv_pulse", 32'(vec_valid), 32'h0);

    do_reset();
    irq_in = 8'h20; tick(); tick();
    inta_first(); inta_second();
    checkOutput("nest_isr5", 32'(isr), 32'h20);
    irq_in = 8'h64; tick();
    checkOutput("nest_irr", 32'(irr), 32'h44);
    tick();
    checkOutput("nest_int_ir2", 32'(int_out), 32'h1);
    imr = 8'h04; tick();
    checkOutput("nest_masked", 32'(int_out), 32'h0);
    smm = 1; imr = 8'h24; tick();
    checkOutput("nest_smm_int", 32'(int_out), 32'h1);
    inta_first();
    checkOutput("nest_smm_vec", 32'(vec_id), 32'h6);
    inta_second();

    do_reset();
    auto_rot = 1; irq_in = 8'h01; tick(); tick();
    inta_first(); inta_second();
    eoi_strb = 1; eoi_specific = 0; tick(); eoi_strb = 0;
    checkOutput("rot_base", 32'(pri_base), 32'h1);
    checkOutput("rot_isr", 32'(isr), 32'h0);
    irq_in = 8'h00; tick(); irq_in = 8'h03; tick(); tick();
    inta_first();
    checkOutput("rot_vec", 32'(vec_id), 32'h1);
    inta_second();

    do_reset();
    set_pri_strb = 1; set_pri_id = 3'd4; tick(); set_pri_strb = 0;
    checkOutput("setpri_base", 32'(pri_base), 32'h5);
    irq_in = 8'h28; tick(); tick();
    inta_first();
    checkOutput("setpri_vec", 32'(vec_id), 32'h5);
    inta_second();

    do_reset();
    auto_rot = 1; irq_in = 8'h01; tick(); tick();
    inta_first(); inta_second();
    eoi_strb = 1; eoi_specific = 0; set_pri_strb = 1; set_pri_id = 3'd4; tick();
    eoi_strb = 0; set_pri_strb = 0;
    checkOutput("setpri_over_eoi", 32'(pri_base), 32'h5);
    checkOutput("setpri_eoi_isr", 32'(isr), 32'h0);

    do_reset();
    inta_first();
    checkOutput("spur_flag", 32'(spurious), 32'h1);
    checkOutput("spur_vec", 32'(vec_id), 32'h7);
    checkOutput("spur_isr", 32'(isr), 32'h0);
    inta_second();
    checkOutput("spur_vv", 32'(vec_valid), 32'h1);
    checkOutput("spur_vv_flag", 32'(spurious), 32'h1);
    tick();
    checkOutput("spur_clear", 32'(spurious), 32'h0);
    aeoi = 1; irq_in = 8'h02; tick(); tick();
    inta_first();
    checkOutput("aeoi_isr_set", 32'(isr), 32'h02);
    inta_second();
    checkOutput("aeoi_isr_clr", 32'(isr), 32'h00);
    checkOutput("aeoi_vv", 32'(vec_valid), 32'h1);
    checkOutput("aeoi_vec", 32'(vec_id), 32'h1);

    do_reset();
    irq_in = 8'h04; tick(); tick();
    inta_first();
    checkOutput("mid_isr", 32'(isr), 32'h04);
    rst_n = 0; irq_in = 8'h00; #1;
    checkOutput("mid_rst_isr", 32'(isr), 32'h0);
    checkOutput("mid_rst_vec", 32'(vec_id), 32'h0);
    checkOutput("mid_rst_spur", 32'(spurious), 32'h0);
    tick(); rst_n = 1; tick();
    inta_first();
    checkOutput("mid_spur", 32'(spurious), 32'h1);
    checkOutput("mid_spur_vec", 32'(vec_id), 32'h7);
    inta_second();
    checkOutput("mid_vv", 32'(vec_valid), 32'h1);

    do_reset();
    $display("[TB] randomized phase");
    for (int c = 0; c < 4000; c++) applyStimulus();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
